vxe_pipe_ctl: RTL

//  Flow-control wrapper placed alongside a vxe_pipe instance of equal NSTAGES.
//  - Upstream valid/ready in, pipe 'en' out, pipe output consumed.
//  - Tracks per-stage valid bits, captures results leaving stage 0 into an

---
 rtl/vxe_pipe_ctl_pkg.sv | 17 +
 rtl/vxe_pipe.sv | 31 +++
 rtl/vxe_pipe_ofifo.sv | 81 ++++++++
 rtl/vxe_pipe_ctl.sv | 67 ++++++
 4 files changed

// File: rtl/vxe_pipe_ctl_pkg.sv
// rtl/vxe_pipe_ctl_pkg.sv - shared defaults and width helpers for the vxe pipe controller
package vxe_pipe_ctl_pkg;

    localparam int VXE_DEFAULT_DW    = 32;
    localparam int VXE_DEFAULT_DEPTH = 4;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int vxe_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy counter needs one extra bit to represent "full".
    function automatic int vxe_cnt_w(input int depth);
        return vxe_ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/vxe_pipe.sv
// rtl/vxe_pipe.sv - enable-gated data pipe, entry at top stage, exit at stage 0
module vxe_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NSTAGES    = 1
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out
);

    logic [DATA_WIDTH-1:0] st_q [NSTAGES];
    logic [DATA_WIDTH-1:0] st_d [NSTAGES];

    assign d_out = st_q[0];

    // Shift toward stage 0 on enable; data regs carry no validity so no reset.
    always_comb begin
        for (int s = 0; s < NSTAGES; s++) st_d[s] = st_q[s];
        if (en) begin
            for (int s = 0; s < NSTAGES - 1; s++) st_d[s] = st_q[s+1];
            st_d[NSTAGES-1] = d_in;
        end
    end

    // Stage data registers.
    always_ff @(posedge clk) begin
        st_q <= st_d;
    end

endmodule

// File: rtl/vxe_pipe_ofifo.sv
// rtl/vxe_pipe_ofifo.sv - output FIFO capturing results leaving the pipe
module vxe_pipe_ofifo
    import vxe_pipe_ctl_pkg::*;
#(
    parameter int DATA_WIDTH = VXE_DEFAULT_DW,
    parameter int DEPTH      = VXE_DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PW = vxe_ptr_w(DEPTH);
    localparam int CW = vxe_cnt_w(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle makes room even when full.
    assign push_ok = push & (~full | pop_ok) & ~flush;
    assign head    = mem_q[rd_ptr_q];

    // Pointer/count update; flush wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Write port into the storage array.
    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = push_data;
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vxe_pipe_ctl.sv
// rtl/vxe_pipe_ctl.sv - valid tracking and stall control wrapped around a vxe_pipe
module vxe_pipe_ctl
    import vxe_pipe_ctl_pkg::*;
#(
    parameter int DATA_WIDTH = VXE_DEFAULT_DW,
    parameter int NSTAGES    = 1,
    parameter int DEPTH      = VXE_DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  i_vld,
    output logic                  i_rdy,
    output logic                  pipe_en,
    input  logic [DATA_WIDTH-1:0] pipe_out,
    output logic                  o_vld,
    input  logic                  o_rdy,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  busy
);

    logic [NSTAGES-1:0] vld_sr_q, vld_sr_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;

    // Stall only when stage 0 holds a result and the FIFO cannot take it.
    // Uses registered state only, so a pop frees the slot one cycle later.
    assign pipe_en = ~vld_sr_q[0] | ~fifo_full;
    assign i_rdy   = pipe_en;
    assign push    = pipe_en & vld_sr_q[0];
    assign o_vld   = ~fifo_empty;
    assign busy    = (|vld_sr_q) | ~fifo_empty;

    // Valid bits follow the pipe data; flush drops everything in flight.
    always_comb begin
        vld_sr_d = vld_sr_q;
        if (flush) begin
            vld_sr_d = '0;
        end else if (pipe_en) begin
            for (int s = 0; s < NSTAGES - 1; s++) vld_sr_d[s] = vld_sr_q[s+1];
            vld_sr_d[NSTAGES-1] = i_vld;
        end
    end

    // Valid shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_sr_q <= '0;
        else     vld_sr_q <= vld_sr_d;
    end

    vxe_pipe_ofifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (pipe_out),
        .pop       (o_rdy),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (o_data)
    );

endmodule
